tap_math_unit: RTL and testbench
================================

Name: tap_math_unit

Overview:
- Pipelined signed fixed-point multiplier for one FIR filter tap: out = tap × data in Q1.3 format (4-bit two's complement, 3 fractional bits, range −1.0 to +0.875).
- Round-half-up to the output grid, then saturate to the Q1.3 range.
- Building block for the audio filter datapath, placed between the coefficient/sample sources and the tap accumulator.
- One registered stage; the input-valid flag travels alongside the data.

Parameters:
- WIDTH, 4, bit width of tap, data and out (two's complement).
- FRAC, 3, number of fractional bits in every operand and in the result; FRAC = WIDTH−1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tap  input  WIDTH  signed Q1.3 coefficient.
- data  input  WIDTH  signed Q1.3 sample.
- in_valid  input  1  tap/data qualifier, sampled on the rising edge of clk.
- out  output  WIDTH  signed Q1.3 product (registered).
- out_valid  output  1  high for one cycle per accepted input.
- sat  output  1  high when the current out value was clamped; meaningful while out_valid=1.

Behaviour:
- Reset (reset=0, asynchronous): out=0, out_valid=0, sat=0 immediately, independent of clk. Hold these values while reset is low.
- Release: the first rising clk edge with reset=1 may accept data.
- Arithmetic, combinational before the register:
  - Full product p = signed(tap) × signed(data), width 2·WIDTH (8 bits, Q2.6).
  - Rounded value r = (p + 2^(FRAC−1)) >>> FRAC, arithmetic shift. This is round-half-toward-+∞. r needs WIDTH+2 bits.
  - Saturate: if r > 2^(WIDTH−1)−1, result = 0111 and sat=1. If r < −2^(WIDTH−1), result = 1000 and sat=1. Otherwise result = r[WIDTH−1:0] and sat=0.
- Only −1.0 × −1.0 = +1.0 overflows in Q1.3. Rounding never pushes a result below −1.0.
- Register stage, on a rising clk edge with reset=1:
  - in_valid=1: out ← result, sat ← saturation flag, out_valid ← 1.
  - in_valid=0: out and sat hold their previous values, out_valid ← 0.
- Latency: exactly 1 clock from the accepting edge to out/out_valid.
- Throughput: one result per clock. Back-to-back valid inputs produce back-to-back valid outputs.
- No backpressure: the downstream block always accepts.
- Reset asserted mid-stream: any in-flight result is discarded. out_valid drops asynchronously, and no result is produced for the cycle in flight.
- Inputs are never X-propagated into out when in_valid=0, because out holds its value.
- Multiplication is commutative: swapping tap and data gives an identical out and sat.

Test Plan:
- Reset: reset=0 with random inputs and in_valid=1 → out=0000, out_valid=0, sat=0 asynchronously. After release, the first accepted input appears one edge later.
- Basic products, in_valid=1 each cycle:
  - tap=0100, data=0100 → out=0010.
  - tap=0111, data=0111 → out=0110.
  - tap=0101, data=0000 → out=0000.
  - All with sat=0 and one-cycle latency.
- Rounding:
  - tap=0010, data=0010 (p=4) → out=0001.
  - tap=0001, data=0001 (p=1) → out=0000.
  - tap=1000, data=0111 (p=−56) → out=1001.
  - tap=1111, data=0010 (p=−2) → out=0000.
- Saturation: tap=1000, data=1000 → out=0111, sat=1. The next vector 0100×0100 → out=0010, sat=0.
- Handshake: alternate in_valid 1,0,1 with changing inputs → out_valid pulses 1,0,1. out holds the prior product during the idle cycle. Assert reset mid-stream → out_valid=0 immediately.
- Exhaustive: all 256 tap/data pairs compared against the reference formula above. Swapped operands must give identical out and sat.

Source files
------------

// File: rtl/tap_math_unit.sv
// tap_math_unit: Q1.3 tap x data multiply with round-half-up and saturation, one register stage
module tap_math_unit #(
  parameter int WIDTH = 4,
  parameter int FRAC  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tap,
  input  logic [WIDTH-1:0] data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sat
);
  localparam logic signed [2*WIDTH:0] RND = (2*WIDTH+1)'(1 << (FRAC-1));
  localparam logic signed [2*WIDTH:0] MAX = (2*WIDTH+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [2*WIDTH:0] MIN = -(2*WIDTH+1)'(1 << (WIDTH-1));
  logic signed [2*WIDTH-1:0] p;
  logic signed [2*WIDTH:0]   r;
  logic                      hi, lo;
  logic [WIDTH-1:0]          res;
  always_comb begin
    p   = (2*WIDTH)'($signed(tap)) * (2*WIDTH)'($signed(data));
    r   = ($signed({p[2*WIDTH-1], p}) + RND) >>> FRAC;
    hi  = r > MAX;
    lo  = r < MIN;
    res = hi ? {1'b0, {(WIDTH-1){1'b1}}} : lo ? {1'b1, {(WIDTH-1){1'b0}}} : r[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= res;
        sat <= hi | lo;
      end
    end
endmodule

// File: tb/tb_tap_math_unit.sv
// tb_tap_math_unit: directed and exhaustive checks of the Q1.3 tap multiplier
module tb_tap_math_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] tap = '0, data = '0;
  logic       in_valid = 1'b0;
  logic [3:0] out;
  logic       out_valid, sat;
  int         nvec = 0, nerr = 0;

  tap_math_unit #(.WIDTH(4), .FRAC(3)) dut (
    .clk(clk), .reset(reset), .tap(tap), .data(data), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  // round-half-up by integer floor division, then clamp
  function automatic void ref_calc(input int t, input int d, output logic [3:0] o, output logic s);
    int q, r;
    q = t * d + 4;
    r = (q >= 0) ? q / 8 : -((-q + 7) / 8);
    s = (r > 7) || (r < -8);
    o = (r > 7) ? 4'b0111 : (r < -8) ? 4'b1000 : 4'(r);
  endfunction

  task automatic apply(input logic [3:0] t, input logic [3:0] d, input logic v);
    @(negedge clk);
    tap = t; data = d; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tap = 4'($urandom); data = 4'($urandom); in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (out !== 4'b0000 || out_valid !== 1'b0 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL reset_hold: out=%b valid=%b sat=%b, need 0000/0/0", out, out_valid, sat);
    end
    @(negedge clk);
    reset = 1'b1;
    apply(4'b0100, 4'b0100, 1'b1);
    nvec++;
    if (out !== 4'b0010 || out_valid !== 1'b1 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release: out=%b valid=%b sat=%b, need 0010/1/0", out, out_valid, sat);
    end
  endtask

  task automatic test_basic();
    logic [3:0] tv [3] = '{4'b0100, 4'b0111, 4'b0101};
    logic [3:0] dv [3] = '{4'b0100, 4'b0111, 4'b0000};
    logic [3:0] ev [3] = '{4'b0010, 4'b0110, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      apply(tv[i], dv[i], 1'b1);
      nvec++;
      if (out !== ev[i] || sat !== 1'b0 || out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL basic_%0d: out=%b sat=%b valid=%b, need %b/0/1", i, out, sat, out_valid, ev[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [3:0] tv [4] = '{4'b0010, 4'b0001, 4'b1000, 4'b1111};
    logic [3:0] dv [4] = '{4'b0010, 4'b0001, 4'b0111, 4'b0010};
    logic [3:0] ev [4] = '{4'b0001, 4'b0000, 4'b1001, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      apply(tv[i], dv[i], 1'b1);
      nvec++;
      if (out !== ev[i] || sat !== 1'b0) begin
        nerr++;
        $display("FAIL round_%0d: out=%b sat=%b, need %b/0", i, out, sat, ev[i]);
      end
    end
  endtask

  task automatic test_saturation();
    apply(4'b1000, 4'b1000, 1'b1);
    nvec++;
    if (out !== 4'b0111 || sat !== 1'b1 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL sat_neg1sq: out=%b sat=%b valid=%b, need 0111/1/1", out, sat, out_valid);
    end
    apply(4'b0100, 4'b0100, 1'b1);
    nvec++;
    if (out !== 4'b0010 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL sat_clear: out=%b sat=%b, need 0010/0", out, sat);
    end
  endtask

  task automatic test_handshake();
    apply(4'b0100, 4'b0100, 1'b1);
    nvec++;
    if (out !== 4'b0010 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL hs_first: out=%b valid=%b, need 0010/1", out, out_valid);
    end
    apply(4'b0111, 4'b0111, 1'b0);
    nvec++;
    if (out !== 4'b0010 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL hs_idle: out=%b valid=%b, need 0010/0", out, out_valid);
    end
    apply(4'b0111, 4'b0111, 1'b1);
    nvec++;
    if (out !== 4'b0110 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL hs_second: out=%b valid=%b, need 0110/1", out, out_valid);
    end
    apply(4'b1000, 4'b1000, 1'b1);
    @(negedge clk);
    tap = 4'b0111; data = 4'b0111; in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    nvec++;
    if (out !== 4'b0000 || out_valid !== 1'b0 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL hs_async_reset: out=%b valid=%b sat=%b, need 0000/0/0", out, out_valid, sat);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (out !== 4'b0000 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL hs_reset_hold: out=%b valid=%b, need 0000/0", out, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_exhaustive();
    logic [3:0] eo;
    logic       es;
    for (int t = -8; t < 8; t++)
      for (int d = -8; d < 8; d++) begin
        ref_calc(t, d, eo, es);
        apply(4'(t), 4'(d), 1'b1);
        nvec++;
        if (out !== eo || sat !== es || out_valid !== 1'b1) begin
          nerr++;
          $display("FAIL exh %0d*%0d: out=%b sat=%b valid=%b, need %b/%b/1", t, d, out, sat, out_valid, eo, es);
        end
        apply(4'(d), 4'(t), 1'b1);
        nvec++;
        if (out !== eo || sat !== es) begin
          nerr++;
          $display("FAIL swap %0d*%0d: out=%b sat=%b, need %b/%b", d, t, out, sat, eo, es);
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_handshake();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
